// File: rtl/sls_pkg.sv
// Shared definitions for the load/store path: access-size codes, sequencer states and
// the alignment rule used to reject accesses before they reach memory.
package sls_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] SZ_UB = 3'b000;
  localparam logic [2:0] SZ_UH = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_D  = 3'b011;
  localparam logic [2:0] SZ_SB = 3'b100;
  localparam logic [2:0] SZ_SH = 3'b101;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAcc0   = 2'd1,
    StAcc1   = 2'd2,
    StFinish = 2'd3
  } state_e;

  // Reserved codes and misaligned halfword/word/doubleword accesses are illegal.
  function automatic logic access_ok(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_UB, SZ_SB: ok = 1'b1;
      SZ_UH, SZ_SH: ok = ~addr_lo[0];
      SZ_W, SZ_D:   ok = (addr_lo == 2'b00);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sls_lane_align.sv
// Byte-lane steering: store data replication and byte enables, plus load-lane
// extraction with zero or sign extension.
module sls_lane_align
  import sls_pkg::*;
(
  input  logic [2:0]        size_i,
  input  logic [1:0]        addr_lo_i,
  input  logic              rw_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [3:0]        be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        sx;

  always_comb begin
    rbyte   = rdata_i[{addr_lo_i, 3'b000} +: 8];
    rhalf   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sx      = size_i[2];
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_UB, SZ_SB: begin
        if (!rw_i) be_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sx & rbyte[7]}}, rbyte};
      end
      SZ_UH, SZ_SH: begin
        if (!rw_i) be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sx & rhalf[15]}}, rhalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sls_mem_access.sv
// Load/store memory access sequencer: one access per START, MOV/MFC handshake,
// two word transfers for doublewords, and extended load data.
module sls_mem_access
  import sls_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              RW,
  input  logic [2:0]        SIZE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA_LO,
  input  logic [DATA_W-1:0] WDATA_HI,
  output logic [DATA_W-1:0] RDATA_LO,
  output logic [DATA_W-1:0] RDATA_HI,
  output logic              BUSY,
  output logic              DONE,
  output logic              FAULT,
  output logic              MEM_MOV,
  output logic              MEM_RW,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [3:0]        MEM_BE,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_MFC
);

  state_e            state_q;
  logic              rw_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wlo_q, whi_q, rlo_q, rhi_q;
  logic              done_q, fault_q, pend_q;

  logic              mem_act;
  logic [ADDR_W-1:0] mem_base;
  logic [3:0]        lane_be;
  logic [DATA_W-1:0] lane_wdata, load_ext;

  sls_lane_align u_lane_align (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .rw_i      (rw_q),
    .wdata_i   ((state_q == StAcc1) ? whi_q : wlo_q),
    .rdata_i   (MEM_RDATA),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .rdata_o   (load_ext)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      rw_q    <= 1'b0;
      size_q  <= 3'b000;
      addr_q  <= '0;
      wlo_q   <= '0;
      whi_q   <= '0;
      rlo_q   <= '0;
      rhi_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Illegal requests are held one cycle so a fault completes two cycles after START.
          if (pend_q) begin
            pend_q  <= 1'b0;
            state_q <= StFinish;
            done_q  <= 1'b1;
            fault_q <= 1'b1;
          end else if (START) begin
            rw_q   <= RW;
            size_q <= SIZE;
            addr_q <= ADDR;
            wlo_q  <= WDATA_LO;
            whi_q  <= WDATA_HI;
            if (access_ok(SIZE, ADDR[1:0])) state_q <= StAcc0;
            else                            pend_q  <= 1'b1;
          end
        end
        StAcc0: begin
          if (MEM_MFC) begin
            if (rw_q) rlo_q <= load_ext;
            if (size_q == SZ_D) begin
              state_q <= StAcc1;
            end else begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end
          end
        end
        StAcc1: begin
          if (MEM_MFC) begin
            if (rw_q) rhi_q <= MEM_RDATA;
            state_q <= StFinish;
            done_q  <= 1'b1;
          end
        end
        StFinish: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_act   = (state_q == StAcc0) || (state_q == StAcc1);
    mem_base  = {addr_q[ADDR_W-1:2], 2'b00};
    MEM_MOV   = mem_act;
    MEM_RW    = mem_act & rw_q;
    MEM_ADDR  = '0;
    MEM_BE    = 4'b0000;
    MEM_WDATA = '0;
    if (mem_act) begin
      MEM_ADDR = (state_q == StAcc1) ? mem_base + ADDR_W'(4) : mem_base;
      MEM_BE   = lane_be;
      if (!rw_q) MEM_WDATA = lane_wdata;
    end
    BUSY     = (state_q != StIdle) | pend_q;
    DONE     = done_q;
    FAULT    = fault_q;
    RDATA_LO = rlo_q;
    RDATA_HI = rhi_q;
  end

endmodule

// File: tb/tb_sls_mem_access.sv
// Scoreboard bench for sls_mem_access: a memory responder checks each MOV request and a
// DONE monitor checks completion status, load data and latency.
module tb_sls_mem_access;
  import sls_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic        RW = 1'b0;
  logic [2:0]  SIZE = 3'b000;
  logic [31:0] ADDR = '0, WDATA_LO = '0, WDATA_HI = '0;
  logic [31:0] RDATA_LO, RDATA_HI, MEM_ADDR, MEM_WDATA;
  logic        BUSY, DONE, FAULT, MEM_MOV, MEM_RW;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_RDATA = '0;
  logic        MEM_MFC = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int resp_wait = 0;

  typedef struct {
    logic        fault;
    logic [31:0] rlo;
    logic [31:0] rhi;
    int          done_cyc;
  } sb_t;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } mem_t;

  sb_t  sb_q[$];
  mem_t mem_q[$];

  sls_mem_access #(.ADDR_W(32)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .START     (START),
    .RW        (RW),
    .SIZE      (SIZE),
    .ADDR      (ADDR),
    .WDATA_LO  (WDATA_LO),
    .WDATA_HI  (WDATA_HI),
    .RDATA_LO  (RDATA_LO),
    .RDATA_HI  (RDATA_HI),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .FAULT     (FAULT),
    .MEM_MOV   (MEM_MOV),
    .MEM_RW    (MEM_RW),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_BE    (MEM_BE),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA),
    .MEM_MFC   (MEM_MFC)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic rw, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] rdata);
    mem_q.push_back('{rw, addr, be, wdata, rdata});
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no DONE within 60 cycles, required one");
    end
    @(negedge CLK);
  endtask

  task automatic run(input logic rw, input logic [2:0] size, input logic [31:0] addr,
                     input logic [31:0] wlo, input logic [31:0] whi, input logic fault,
                     input logic [31:0] rlo, input logic [31:0] rhi, input int lat);
    int d0;
    @(negedge CLK);
    d0 = done_cnt;
    sb_q.push_back('{fault, rlo, rhi, cyc + lat});
    RW = rw; SIZE = size; ADDR = addr; WDATA_LO = wlo; WDATA_HI = whi; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(d0);
  endtask

  // Memory responder: checks each request on its first cycle, then returns MFC after
  // resp_wait extra cycles.
  initial begin : responder
    int   cnt;
    mem_t cur;
    cnt = 0;
    cur = '{1'b0, 32'h0, 4'h0, 32'h0, 32'h0};
    forever begin
      @(negedge CLK);
      MEM_MFC = 1'b0;
      if (!MEM_MOV) begin
        cnt = 0;
      end else begin
        if (cnt == 0) begin
          if (mem_q.size() == 0) begin
            chk("mem_mov_unexpected", 32'(MEM_MOV), 32'd0);
            cur = '{1'b0, 32'h0, 4'h0, 32'h0, 32'h0};
          end else begin
            cur = mem_q.pop_front();
            chk("mem_rw", 32'(MEM_RW), 32'(cur.rw));
            chk("mem_addr", MEM_ADDR, cur.addr);
            chk("mem_be", 32'(MEM_BE), 32'(cur.be));
            chk("mem_wdata", MEM_WDATA, cur.wdata);
          end
        end
        if (cnt >= resp_wait) begin
          MEM_MFC   = 1'b1;
          MEM_RDATA = cur.rdata;
          cnt       = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge CLK);
      if (DONE) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          chk("done_unexpected", 32'(DONE), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("fault", 32'(FAULT), 32'(e.fault));
          chk("rdata_lo", RDATA_LO, e.rlo);
          chk("rdata_hi", RDATA_HI, e.rhi);
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("busy_at_done", 32'(BUSY), 32'd1);
        end
      end else if (FAULT) begin
        chk("fault_without_done", 32'(FAULT), 32'd0);
      end
    end
  end

  initial begin : stimulus
    int d0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_fault", 32'(FAULT), 32'd0);
    chk("rst_mov", 32'(MEM_MOV), 32'd0);
    chk("rst_mem_rw", 32'(MEM_RW), 32'd0);
    chk("rst_mem_addr", MEM_ADDR, 32'd0);
    chk("rst_mem_be", 32'(MEM_BE), 32'd0);
    chk("rst_mem_wdata", MEM_WDATA, 32'd0);
    chk("rst_rdata_lo", RDATA_LO, 32'd0);
    chk("rst_rdata_hi", RDATA_HI, 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Loads and stores of every lane width.
    resp_wait = 0;
    push_mem(1'b1, 32'h100, 4'hF, 32'h0, 32'h80AA_BBCC);
    run(1'b1, SZ_SB, 32'h103, 32'h0, 32'h0, 1'b0, 32'hFFFF_FF80, 32'h0, 2);
    push_mem(1'b0, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0);
    run(1'b0, SZ_UH, 32'h202, 32'h1234_ABCD, 32'h0, 1'b0, 32'hFFFF_FF80, 32'h0, 2);
    resp_wait = 1;
    push_mem(1'b1, 32'h100, 4'hF, 32'h0, 32'hDEAD_BEEF);
    run(1'b1, SZ_UB, 32'h101, 32'h0, 32'h0, 1'b0, 32'h0000_00BE, 32'h0, 3);
    resp_wait = 0;
    push_mem(1'b1, 32'h0, 4'hF, 32'h0, 32'h8001_7FFF);
    run(1'b1, SZ_SH, 32'h2, 32'h0, 32'h0, 1'b0, 32'hFFFF_8001, 32'h0, 2);
    push_mem(1'b1, 32'h4, 4'hF, 32'h0, 32'h8001_7FFF);
    run(1'b1, SZ_UH, 32'h4, 32'h0, 32'h0, 1'b0, 32'h0000_7FFF, 32'h0, 2);
    push_mem(1'b0, 32'h0, 4'b0010, 32'h5A5A_5A5A, 32'h0);
    run(1'b0, SZ_SB, 32'h1, 32'h1234_565A, 32'h0, 1'b0, 32'h0000_7FFF, 32'h0, 2);
    push_mem(1'b0, 32'h20, 4'hF, 32'hAAAA_0001, 32'h0);
    push_mem(1'b0, 32'h24, 4'hF, 32'hBBBB_0002, 32'h0);
    run(1'b0, SZ_D, 32'h20, 32'hAAAA_0001, 32'hBBBB_0002, 1'b0, 32'h0000_7FFF, 32'h0, 3);

    // Doubleword load wrapping the address space, two wait cycles per word.
    resp_wait = 2;
    push_mem(1'b1, 32'hFFFF_FFFC, 4'hF, 32'h0, 32'h1111_2222);
    push_mem(1'b1, 32'h0000_0000, 4'hF, 32'h0, 32'h3333_4444);
    run(1'b1, SZ_D, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'h1111_2222, 32'h3333_4444, 7);

    // Faults: no memory request, RDATA untouched.
    run(1'b1, SZ_W, 32'h2, 32'h0, 32'h0, 1'b1, 32'h1111_2222, 32'h3333_4444, 2);
    run(1'b1, 3'b110, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1111_2222, 32'h3333_4444, 2);
    run(1'b0, SZ_UH, 32'h1, 32'h0, 32'h0, 1'b1, 32'h1111_2222, 32'h3333_4444, 2);
    run(1'b0, 3'b111, 32'h8, 32'h0, 32'h0, 1'b1, 32'h1111_2222, 32'h3333_4444, 2);

    // A second START while busy must not create another access.
    resp_wait = 3;
    push_mem(1'b1, 32'h40, 4'hF, 32'h0, 32'hCAFE_F00D);
    @(negedge CLK);
    d0 = done_cnt;
    sb_q.push_back('{1'b0, 32'hCAFE_F00D, 32'h3333_4444, cyc + 5});
    RW = 1'b1; SIZE = SZ_W; ADDR = 32'h40; START = 1'b1;
    @(negedge CLK);
    ADDR = 32'h80;
    @(negedge CLK);
    START = 1'b0;
    wait_done(d0);

    // Reset in the middle of an access aborts it without DONE.
    resp_wait = 10;
    push_mem(1'b1, 32'h300, 4'hF, 32'h0, 32'h0);
    @(negedge CLK);
    RW = 1'b1; SIZE = SZ_W; ADDR = 32'h300; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("abort_mov_before", 32'(MEM_MOV), 32'd1);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("abort_mov", 32'(MEM_MOV), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_mem_addr", MEM_ADDR, 32'd0);
    chk("abort_rdata_lo", RDATA_LO, 32'd0);
    chk("abort_rdata_hi", RDATA_HI, 32'd0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (5) @(negedge CLK);

    resp_wait = 0;
    push_mem(1'b1, 32'h8, 4'hF, 32'h0, 32'h1234_5678);
    run(1'b1, SZ_W, 32'h8, 32'h0, 32'h0, 1'b0, 32'h1234_5678, 32'h0, 2);

    chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    chk("mem_leftover", 32'(mem_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sls_mem_access.md
# sls_mem_access

Load/store memory access sequencer. It sits directly downstream of the load/store size decoder and consumes its 3-bit access-type code. The control unit issues one access per START; the block drives the data-memory MOV/MFC handshake, sequences two word transfers for doublewords, positions byte and halfword data on the byte lanes, and returns zero- or sign-extended load data.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, memory data width (fixed at 32; the parameter exists for the package only)

Ports:
- CLK  in  1  clock. Everything is rising-edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- START  in  1  one-cycle request strobe from the control unit.
- RW  in  1  1 = load, 0 = store.
- SIZE  in  3  access-type code from the size decoder.
- ADDR  in  32  byte address.
- WDATA_LO  in  32  store data, first word.
- WDATA_HI  in  32  store data, second word. Used for doubleword only.
- RDATA_LO  out  32  load result, first word, extended as required.
- RDATA_HI  out  32  load result, second word. Doubleword only.
- BUSY  out  1  high while an access is in progress.
- DONE  out  1  one-cycle completion pulse.
- FAULT  out  1  one-cycle pulse, coincident with DONE, on a misaligned access or a reserved code.
- MEM_MOV  out  1  memory request.
- MEM_RW  out  1  1 = read.
- MEM_ADDR  out  32  word-aligned memory address.
- MEM_BE  out  4  byte enables. Bit i enables byte lane i (little-endian).
- MEM_WDATA  out  32  memory write data.
- MEM_RDATA  in  32  memory read data. Valid when MEM_MFC is high.
- MEM_MFC  in  1  memory function complete. A one-cycle pulse per access.

## Operation
- SIZE codes:
  - 000 = unsigned byte
  - 001 = unsigned halfword
  - 010 = word
  - 011 = doubleword
  - 100 = signed byte
  - 101 = signed halfword
  - 110 and 111 are reserved.
- On stores, codes 100 and 101 behave as 000 and 001.
- Alignment rules:
  - Halfword requires ADDR[0]=0.
  - Word and doubleword require ADDR[1:0]=0.
  - A reserved code or a violation makes no memory access. The block goes IDLE→FINISH with FAULT set. RDATA is unchanged.
- The block latches RW, SIZE, ADDR and WDATA in IDLE when START=1. START is ignored while BUSY=1.
- FSM states IDLE, ACC0, ACC1, FINISH:
  - IDLE→ACC0 on a legal START.
  - ACC0→ACC1 on MFC if the code is doubleword. Otherwise ACC0→FINISH on MFC.
  - ACC1→FINISH on MFC.
  - FINISH→IDLE unconditionally.
- MEM_MOV is high in ACC0 and ACC1, and low otherwise.
- MEM_ADDR is {ADDR[31:2],2'b00} in ACC0 and that value +4 in ACC1. The +4 wraps modulo 2^32.
- Store lanes:
  - Byte: WDATA_LO[7:0] is replicated to all 4 lanes, and MEM_BE is a one-hot on ADDR[1:0].
  - Halfword: WDATA_LO[15:0] is replicated to both halves, and MEM_BE is 0011 or 1100 by ADDR[1].
  - Word and doubleword: MEM_BE=1111. MEM_WDATA is WDATA_LO in ACC0 and WDATA_HI in ACC1.
- Reads: MEM_BE=1111. On MFC in ACC0, the lane selected by ADDR[1:0] is extracted and zero-extended (000/001) or sign-extended (100/101) into RDATA_LO. A word is stored unmodified. On MFC in ACC1, MEM_RDATA goes into RDATA_HI.
- Stores do not modify RDATA_LO or RDATA_HI.

## Timing
- Reset values: all outputs 0, FSM in IDLE, RDATA registers 0. Asserting RESET_N low mid-access aborts immediately. MEM_MOV drops asynchronously, and no DONE is produced.
- BUSY is high in ACC0, ACC1 and FINISH.
- DONE and FAULT are registered and high only in FINISH.
- Latency from START to DONE:
  - Single access: 2 cycles plus memory wait cycles. MFC arriving in the first ACC0 cycle gives DONE at cycle 2.
  - Doubleword: minimum 3 cycles.
  - Fault: exactly 2 cycles.
- A START in the FINISH cycle is ignored. The earliest accepted START is the cycle after DONE.
- An MFC pulse outside ACC0 or ACC1 is ignored.
- RDATA is stable from FINISH until the next load's MFC.

## Structure
- Package sls_pkg holds:
  - the SIZE code localparams (SZ_UB, SZ_UH, SZ_W, SZ_D, SZ_SB, SZ_SH)
  - the state encodings
  - DATA_W
- The size decoder imports the same package.
- One sub-module, sls_lane_align, is purely combinational. It takes SIZE, ADDR[1:0], RW and the data, and produces MEM_BE, MEM_WDATA and the extended load word.
- The FSM and registers stay in the top level.

## Test plan
- Signed-byte load (SIZE=100) at 0x103 with MEM_RDATA=0x80AA_BBCC and MFC on the first cycle → MEM_ADDR=0x100, RDATA_LO=0xFFFF_FF80, DONE 2 cycles after START, FAULT=0.
- Unsigned-halfword store at 0x202 with WDATA_LO=0x1234_ABCD → MEM_BE=1100, MEM_WDATA=0xABCD_ABCD, MEM_RW=0.
- Doubleword load at 0xFFFF_FFFC with MFC delayed 2 cycles per access → MEM_ADDR=0xFFFF_FFFC then 0x0000_0000, RDATA_LO and RDATA_HI captured, DONE at cycle 7.
- Word load at 0x0000_0002, and SIZE=110 at 0x0 → no MEM_MOV, DONE and FAULT pulse 2 cycles after START.
- RESET_N pulled low during ACC0, and START asserted while BUSY → all outputs 0 with no DONE, and the extra START produces no second access.
